// File: rtl/ahb_wbuf_pkg.sv
// Shared types for the AHB posted-write buffer.
// Holds htrans codes, the FIFO entry layout and the master FSM states.
package ahb_wbuf_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [6:0]  chk;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WDATA,
        M_RDATA
    } mst_state_t;

endpackage

// File: rtl/ahb_wbuf_fifo.sv
// Synchronous FIFO of buffered writes with head and next-entry read ports.
// WBUF_RAW_FWD_EN additionally exposes the storage for read forwarding.
module wbuf_fifo
    import ahb_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             s_clk_i,
    input  logic             s_reset_i,
    input  logic             push,
    input  wbuf_entry_t      din,
    input  logic             pop,
    output wbuf_entry_t      head,
    output wbuf_entry_t      next_ent,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
`ifdef WBUF_RAW_FWD_EN
    ,output wbuf_entry_t     ents [DEPTH]
    ,output logic [PTR_W-1:0] rd_ptr_o
`endif
);

    wbuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head     = mem[rd_ptr];
    assign next_ent = mem[rd_ptr + PTR_W'(1)];
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);

`ifdef WBUF_RAW_FWD_EN
    assign ents     = mem;
    assign rd_ptr_o = rd_ptr;
`endif

endmodule

// File: rtl/ahb_wbuf.sv
// Posted-write buffer between the core AHB master and a RAM port.
// Define WBUF_RAW_FWD_EN to complete matching word reads from the buffer.
module ahb_wbuf
    import ahb_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic [31:0] s_haddr_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic        s_hsel_i,
    input  logic [6:0]  s_hwchecksum_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_hready_o,
    output logic        s_hresp_o,
    output logic [31:0] m_haddr_o,
    output logic [31:0] m_hwdata_o,
    output logic [6:0]  m_hwchecksum_o,
    output logic [2:0]  m_hsize_o,
    output logic [1:0]  m_htrans_o,
    output logic        m_hwrite_o,
    output logic        m_hsel_o,
    input  logic [31:0] m_hrdata_i,
    input  logic [6:0]  m_hrchecksum_i,
    input  logic        m_hready_i,
    input  logic        m_hresp_i,
    output logic        idle_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    mst_state_t     state_q, state_d;
    logic           pend_valid_q, pend_write_q;
    logic [31:0]    pend_addr_q;
    logic [2:0]     pend_size_q;
    logic           err_q;
    logic           qual, wr_phase, rd_phase;
    logic           push, pop, full, empty;
    logic [PTR_W:0] count;
    wbuf_entry_t    din, head, next_ent, fwd_ent;
    logic           fwd_hit;
    logic           unused_bits;

    assign qual     = s_hsel_i & s_htrans_i[1] & s_hready_o;
    assign wr_phase = pend_valid_q & pend_write_q;
    assign rd_phase = pend_valid_q & ~pend_write_q;
    assign push     = wr_phase & ~full;
    assign din      = '{addr: pend_addr_q, size: pend_size_q,
                        data: s_hwdata_i, chk: s_hwchecksum_i};

`ifdef WBUF_RAW_FWD_EN
    wbuf_entry_t      ents [DEPTH];
    logic [PTR_W-1:0] rd_ptr;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PTR_W+1)'(i) < count) &&
                (ents[rd_ptr + PTR_W'(i)].addr == pend_addr_q) &&
                (ents[rd_ptr + PTR_W'(i)].size == 3'd2) &&
                (pend_size_q == 3'd2)) begin
                fwd_hit = rd_phase;
                fwd_ent = ents[rd_ptr + PTR_W'(i)];
            end
        end
    end
`else
    assign fwd_hit = 1'b0;
    assign fwd_ent = '0;
`endif

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .s_clk_i   (s_clk_i),
        .s_reset_i (s_reset_i),
        .push      (push),
        .din       (din),
        .pop       (pop),
        .head      (head),
        .next_ent  (next_ent),
        .full      (full),
        .empty     (empty),
        .count     (count)
`ifdef WBUF_RAW_FWD_EN
        ,.ents     (ents)
        ,.rd_ptr_o (rd_ptr)
`endif
    );

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q      <= M_IDLE;
            pend_valid_q <= 1'b0;
            pend_write_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_size_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (s_hready_o) begin
                pend_valid_q <= qual;
                if (qual) begin
                    pend_write_q <= s_hwrite_i;
                    pend_addr_q  <= s_haddr_i;
                    pend_size_q  <= s_hsize_i;
                end
            end
            if ((state_q == M_WDATA) && m_hresp_i) err_q <= 1'b1;
            else if (err_clr_i)                    err_q <= 1'b0;
        end
    end

    // Core side: writes gate only on FIFO space, reads mirror the RAM.
    always_comb begin
        s_hready_o     = 1'b1;
        s_hresp_o      = 1'b0;
        s_hrdata_o     = m_hrdata_i;
        s_hrchecksum_o = m_hrchecksum_i;
        if (wr_phase) begin
            s_hready_o = ~full;
        end else if (rd_phase) begin
            if (fwd_hit) begin
                s_hrdata_o     = fwd_ent.data;
                s_hrchecksum_o = fwd_ent.chk;
            end else if (state_q == M_RDATA) begin
                s_hready_o = m_hready_i;
                s_hresp_o  = m_hresp_i;
            end else begin
                s_hready_o = 1'b0;
            end
        end
        if (s_reset_i) begin
            s_hready_o = 1'b1;
            s_hresp_o  = 1'b0;
        end
    end

    // Address phases advance only on m_hready_i, so outputs hold in waits.
    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        m_htrans_o     = HTRANS_IDLE;
        m_haddr_o      = head.addr;
        m_hsize_o      = head.size;
        m_hwrite_o     = 1'b1;
        m_hwdata_o     = head.data;
        m_hwchecksum_o = head.chk;
        unique case (state_q)
            M_IDLE: begin
                if (!empty) begin
                    m_htrans_o = HTRANS_NONSEQ;
                    if (m_hready_i) state_d = M_WDATA;
                end else if (rd_phase && !fwd_hit) begin
                    m_htrans_o = HTRANS_NONSEQ;
                    m_haddr_o  = pend_addr_q;
                    m_hsize_o  = pend_size_q;
                    m_hwrite_o = 1'b0;
                    if (m_hready_i) state_d = M_RDATA;
                end
            end
            M_WDATA: begin
                if (count > (PTR_W+1)'(1)) begin
                    m_htrans_o = HTRANS_NONSEQ;
                    m_haddr_o  = next_ent.addr;
                    m_hsize_o  = next_ent.size;
                end
                if (m_hready_i) begin
                    pop     = 1'b1;
                    state_d = (count > (PTR_W+1)'(1)) ? M_WDATA : M_IDLE;
                end
            end
            M_RDATA: begin
                if (m_hready_i) state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
        if (s_reset_i) m_htrans_o = HTRANS_IDLE;
    end

    assign m_hsel_o = m_htrans_o[1];
    assign idle_o   = s_reset_i |
                      (empty & (state_q == M_IDLE) & ~pend_valid_q);
    assign err_o    = err_q & ~s_reset_i;

    assign unused_bits = ^{s_htrans_i[0], next_ent.data, next_ent.chk,
                           fwd_ent.addr, fwd_ent.size};

endmodule

// File: doc/ahb_wbuf.md
Name: ahb_wbuf

Overview:
- Posted-write buffer between the core data AHB3-Lite master and one port of the shared dual-port RAM controller.
- Accepts core writes with zero wait states into a small FIFO and drains them to the RAM port in order.
- Reads stall until the FIFO is empty, then pass through, so memory ordering is preserved.
- Per-word write checksums travel with the data; read checksums pass through unchanged.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, never overridden.

Ports:
- s_clk_i  input  1  clock
- s_reset_i  input  1  synchronous active-high reset
- s_haddr_i  input  32  core address
- s_hwdata_i  input  32  core write data
- s_hsize_i  input  3  core transfer size
- s_htrans_i  input  2  core transfer type
- s_hwrite_i  input  1  core write
- s_hsel_i  input  1  core select
- s_hwchecksum_i  input  7  core write-data checksum
- s_hrdata_o  output  32  read data to core
- s_hrchecksum_o  output  7  read checksum to core
- s_hready_o  output  1  ready to core
- s_hresp_o  output  1  response to core
- m_haddr_o  output  32  address to RAM port
- m_hwdata_o  output  32  write data to RAM port
- m_hwchecksum_o  output  7  write checksum to RAM port
- m_hsize_o  output  3  size to RAM port
- m_htrans_o  output  2  transfer type (IDLE=0, NONSEQ=2 only)
- m_hwrite_o  output  1  write to RAM port
- m_hsel_o  output  1  select to RAM port
- m_hrdata_i  input  32  RAM read data
- m_hrchecksum_i  input  7  RAM read checksum
- m_hready_i  input  1  RAM ready
- m_hresp_i  input  1  RAM response
- idle_o  output  1  FIFO empty and master side idle (fence)
- err_o  output  1  sticky: a drained write received an ERROR response
- err_clr_i  input  1  clears err_o

Behaviour:
- Interface: one clock, s_clk_i. Reset s_reset_i is synchronous and active-high. Reset clears the FIFO, the FSM and the pending registers; buffered writes are discarded. Outputs during reset: s_hready_o=1, s_hresp_o=0, m_htrans_o=0, m_hsel_o=0, idle_o=1, err_o=0.
- Transfer qualifier: s_hsel_i & s_htrans_i[1] & s_hready_o. On a qualified transfer, address, size and write are registered as a pending data phase.
- Write data phase: s_hready_o = (count < DEPTH). On the cycle s_hready_o=1, push {pending addr, size, s_hwdata_i, s_hwchecksum_i}. When the FIFO is full, the data phase stalls until a pop. There is no combinational path from m_hready_i to s_hready_o on writes.
- Read data phase: s_hready_o=0 until count==0 and the FSM is in M_IDLE. The FSM then issues the read.
  - s_hready_o, s_hresp_o, s_hrdata_o and s_hrchecksum_o mirror the m_* inputs during the read data phase.
  - A two-cycle ERROR from the RAM is forwarded as a two-cycle ERROR to the core.
- Master FSM states: M_IDLE, M_WDATA, M_RDATA.
  - M_IDLE: if count>0, drive the head entry as NONSEQ write → M_WDATA. Else, if a read is pending, drive the pending read as NONSEQ → M_RDATA. Else drive IDLE.
  - M_WDATA: drive the head data and checksum. When m_hready_i=1, pop. If more entries remain, drive the next entry's address in the same cycle (back-to-back drain) and stay. Otherwise → M_IDLE.
  - M_RDATA: when m_hready_i=1 → M_IDLE.
- Master address outputs are held stable while m_hready_i=0.
- m_hresp_i=1 in M_WDATA sets err_o. err_clr_i clears it; a set in the same cycle as a clear wins.
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo DEPTH. Count has PTR_W+1 bits.
- idle_o = (count==0) & M_IDLE & no pending data phase.

Optional Feature:
- Macro: WBUF_RAW_FWD_EN.
- Defined: a word read (size==2) whose address exactly matches a FIFO entry of size 2 completes from the youngest matching entry.
  - Completes in one cycle with OKAY; data and checksum come from the entry.
  - No master-side read is issued.
  - All other reads keep the drain-then-read rule.
- Undefined: all reads wait for the drain.

Decomposition:
- Package ahb_wbuf_pkg holds:
  - htrans constants (HTRANS_IDLE, HTRANS_NONSEQ);
  - the wbuf_entry_t struct {addr[31:0], size[2:0], data[31:0], chk[6:0]};
  - the mst_state_t enum.
- Sub-module wbuf_fifo: parameterised synchronous FIFO of wbuf_entry_t with push, pop, full, empty and count, and a read port for the head and the next entry.

Test Plan:
- Reset, then 4 back-to-back word writes to 0x100..0x10C → s_hready_o stays 1. m_* shows 4 NONSEQ writes on consecutive cycles with m_hready_i=1. idle_o=1 after the last pop.
- 6 writes with m_hready_i held 0, DEPTH=4 → 5th data phase stalls (s_hready_o=0). It is released the cycle after the first pop.
- Write 0xDEADBEEF to 0x200, then read 0x200 → the read is issued only after the write drains. Core receives 0xDEADBEEF plus the RAM checksum.
- RAM returns ERROR on a drained write → err_o=1 and stays set. err_clr_i pulse → 0. Core never sees s_hresp_o=1.
- Read with two-cycle ERROR from RAM → core sees s_hresp_o=1 with s_hready_o=0, then 1.
- Assert s_reset_i with 3 entries buffered → m_htrans_o=0 next cycle, count=0, no further writes emitted.
